// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, tags ROM responses, and buffers one
// word so decode stalls never drop or repeat an instruction.
module if_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 4
) (
    input  logic            clk_50,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            id_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            halted
);

    typedef enum logic {RUN, HALT} fsm_t;

    fsm_t            fsm_q;
    fsm_t            fsm_d;

    logic [XLEN-1:0] pc_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic            hold_valid_q;
    logic [XLEN-1:0] hold_pc_q;
    logic [XLEN-1:0] hold_inst_q;

    logic            sel_valid;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] sel_inst;
    logic            run;
    logic            accept;
    logic            pc_step;
    logic [XLEN-1:0] redirect_tgt;

    assign imem_addr    = pc_q;
    assign run          = (fsm_q == RUN);
    assign sel_valid    = hold_valid_q | rsp_valid_q;
    assign sel_pc       = hold_valid_q ? hold_pc_q : rsp_pc_q;
    assign sel_inst     = hold_valid_q ? hold_inst_q : imem_inst;
    assign id_valid     = sel_valid & run & ~redirect_valid;
    assign id_pc        = sel_valid ? sel_pc : '0;
    assign id_inst      = sel_valid ? sel_inst : '0;
    assign accept       = id_valid & ~id_stall;
    assign pc_step      = ~id_valid | ~id_stall;
    assign redirect_tgt = redirect_pc & ~(XLEN'(3));

    always_ff @(posedge clk_50) begin
        if (rst) begin
            fsm_q <= RUN;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // A zero word may sit in the shadow of an older branch, so only a
    // redirect (or reset) leaves HALT.
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            RUN: begin
                if (!redirect_valid && accept && id_inst == '0) begin
                    fsm_d = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    fsm_d = RUN;
                end
            end
            default: fsm_d = RUN;
        endcase
    end

    always_comb begin
        halted = (fsm_q == HALT);
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            rsp_valid_q  <= 1'b0;
            rsp_pc_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_inst_q  <= '0;
        end else if (redirect_valid) begin
            pc_q         <= redirect_tgt;
            rsp_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else if (run) begin
            // The ROM re-reads pc_q every cycle, so the tag always follows it.
            rsp_pc_q    <= pc_q;
            rsp_valid_q <= 1'b1;
            if (pc_step) begin
                pc_q <= pc_q + XLEN'(PC_INC);
            end
            if (!id_stall) begin
                hold_valid_q <= 1'b0;
            end else if (!hold_valid_q && rsp_valid_q) begin
                hold_valid_q <= 1'b1;
                hold_pc_q    <= rsp_pc_q;
                hold_inst_q  <= imem_inst;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: ROM model plus an in-order scoreboard of
// the PCs decode should accept.
module tb_if_fetch_stage;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        halted;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    logic [31:0] frz;
    bit          ok;

    always #5 clk_50 = ~clk_50;

    if_fetch_stage #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .PC_INC(4)
    ) dut (
        .clk_50(clk_50),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_inst(imem_inst),
        .id_stall(id_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_pc(id_pc),
        .id_inst(id_inst),
        .halted(halted)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'd20:  return 32'hff810113;
            32'd24:  return 32'h01412223;
            32'd28:  return 32'h01312023;
            32'd40:  return 32'h00000513;
            32'd144: return 32'h00c5c533;
            default: return (a < 32'd148) ? {a[15:0], 16'h0093} : 32'h0;
        endcase
    endfunction

    always @(posedge clk_50) imem_inst <= rom_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_run(input int lo, input int hi);
        for (int p = lo; p <= hi; p += 4) sb.push_back(32'(p));
    endtask

    task automatic next();
        @(posedge clk_50);
        #1;
    endtask

    task automatic look();
        @(negedge clk_50);
    endtask

    // Advance until imem_addr reaches a, leaving the bench at posedge+1.
    task automatic wait_addr(input logic [31:0] a, input int budget,
                             input string tag);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            next();
            if (imem_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(tag, imem_addr, a);
    endtask

    always @(negedge clk_50) begin
        if (id_valid && !id_stall) begin
            if (sb.size() == 0) begin
                chk("sb_extra", 32'(sb.size()), 32'd1);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_pc", id_pc, e);
                chk("sb_inst", id_inst, rom_word(e));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        next();
        next();
        rst = 1'b0;
        look();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);

        push_run(0, 52);
        next();
        look();
        chk("first_valid", 32'(id_valid), 32'd1);
        chk("first_pc", id_pc, 32'h0);

        // stall three cycles while pc 24 sits in decode
        wait_addr(32'd28, 20, "tmo_stall");
        id_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next();
            if (k == 3) id_stall = 1'b0;
            look();
            chk($sformatf("stall_pc%0d", k), id_pc, 32'd24);
            chk($sformatf("stall_inst%0d", k), id_inst, 32'h01412223);
            chk($sformatf("stall_addr%0d", k), imem_addr, 32'd28);
        end
        next();
        look();
        chk("rel_pc", id_pc, 32'd28);
        chk("rel_inst", id_inst, 32'h01312023);

        // redirect to 40 while 56 is presented
        wait_addr(32'd60, 20, "tmo_redir1");
        redirect_valid = 1'b1;
        redirect_pc = 32'd40;
        push_run(40, 44);
        look();
        chk("rd1_pc56", id_pc, 32'd56);
        chk("rd1_valid0", 32'(id_valid), 32'd0);
        next();
        redirect_valid = 1'b0;
        look();
        chk("rd1_valid1", 32'(id_valid), 32'd0);
        chk("rd1_addr", imem_addr, 32'd40);
        next();
        look();
        chk("rd1_tgt_v", 32'(id_valid), 32'd1);
        chk("rd1_tgt_pc", id_pc, 32'd40);
        chk("rd1_tgt_inst", id_inst, 32'h00000513);

        // redirect to a misaligned target while the hold buffer is full
        wait_addr(32'd52, 10, "tmo_redir2");
        id_stall = 1'b1;
        look();
        chk("rd2_stall_pc", id_pc, 32'd48);
        next();
        redirect_valid = 1'b1;
        redirect_pc = 32'd42;
        push_run(40, 148);
        look();
        chk("rd2_valid0", 32'(id_valid), 32'd0);
        next();
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        look();
        chk("rd2_valid1", 32'(id_valid), 32'd0);
        chk("rd2_addr", imem_addr, 32'd40);
        next();
        look();
        chk("rd2_tgt_pc", id_pc, 32'd40);

        // run into the zero word at 148
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            next();
            look();
            if (id_valid && id_pc == 32'd148) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("tmo_halt", id_pc, 32'd148);
        chk("zero_inst", id_inst, 32'h0);
        next();
        look();
        chk("halt_on", 32'(halted), 32'd1);
        chk("halt_valid", 32'(id_valid), 32'd0);
        frz = imem_addr;
        next();
        next();
        look();
        chk("halt_frozen", imem_addr, frz);
        chk("halt_hold", 32'(halted), 32'd1);

        next();
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        push_run(0, 96);
        look();
        next();
        redirect_valid = 1'b0;
        look();
        chk("unhalt", 32'(halted), 32'd0);
        chk("unhalt_addr", imem_addr, 32'd0);
        next();
        look();
        chk("unhalt_pc", id_pc, 32'd0);
        chk("unhalt_v", 32'(id_valid), 32'd1);

        // reset while the hold buffer has pc 100
        wait_addr(32'd104, 40, "tmo_rst");
        id_stall = 1'b1;
        next();
        rst = 1'b1;
        look();
        chk("rst2_pre_pc", id_pc, 32'd100);
        next();
        rst = 1'b0;
        id_stall = 1'b0;
        push_run(0, 8);
        look();
        chk("rst2_valid", 32'(id_valid), 32'd0);
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_addr", imem_addr, 32'd0);
        next();
        look();
        chk("rst2_pc", id_pc, 32'd0);

        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next();
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        id_stall = 1'b1;
        look();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
